// File: rtl/io_bus_responder.sv
// io_bus_responder: CPU IO-port peripheral with LEDs, switches, key and ms timer.
// Define IO_BUS_TIMER_EN to build the millisecond timer behind offset 0x078.
module io_bus_responder #(
    parameter int CLK_FREQ_HZ = 23_000_000,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic        iClk,
    input  logic        iResetN,
    input  logic        iDoIoRead,
    input  logic        iDoIoWrite,
    input  logic [31:0] iAddress,
    input  logic [31:0] iDataToStore,
    output logic [15:0] oDataFromIo,
    input  logic [23:0] iSwitch,
    input  logic        iKey,
    output logic [23:0] oLed,
    output logic        oAddrError
);

    // Debounce window in cycles; a zero window still needs one cycle.
    localparam int DB_RAW    = DEBOUNCE_MS * CLK_FREQ_HZ / 1000;
    localparam int DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    localparam logic [9:0] OFF_LED_LO = 10'h060;
    localparam logic [9:0] OFF_LED_HI = 10'h062;
    localparam logic [9:0] OFF_SW_LO  = 10'h070;
    localparam logic [9:0] OFF_SW_HI  = 10'h072;
    localparam logic [9:0] OFF_KEY    = 10'h074;
    localparam logic [9:0] OFF_TIMER  = 10'h078;

    logic        inIoRegion;
    logic [9:0]  offset;
    logic        rdEn;
    logic        wrEn;
    logic        selLedLo;
    logic        selLedHi;
    logic        selSwLo;
    logic        selSwHi;
    logic        selKey;
    logic        selTimer;
    logic        mapped;
    logic [15:0] readValue;
    logic [15:0] timerValue;

    logic [23:0] swMeta;
    logic [23:0] swSync;

    logic            keyMeta;
    logic            keySync;
    logic            keyLevel;
    logic [DB_W-1:0] dbCnt;
    logic            keyFlip;
    logic            keyRise;
    logic            keyClr;
    logic            keyLatch;

    logic unusedStoreHi;

    assign unusedStoreHi = ^iDataToStore[31:16];

    // Address decode: only the top 1 KiB of the address space is IO.
    assign inIoRegion = &iAddress[31:10];
    assign offset     = iAddress[9:0];
    assign rdEn       = inIoRegion & iDoIoRead;
    assign wrEn       = inIoRegion & iDoIoWrite;

    assign selLedLo = (offset == OFF_LED_LO);
    assign selLedHi = (offset == OFF_LED_HI);
    assign selSwLo  = (offset == OFF_SW_LO);
    assign selSwHi  = (offset == OFF_SW_HI);
    assign selKey   = (offset == OFF_KEY);
    assign selTimer = (offset == OFF_TIMER);

    // The timer offset stays mapped even when the timer is not built.
    assign mapped = selLedLo | selLedHi | selSwLo
                  | selSwHi | selKey | selTimer;

    // Read mux from registered state; zero-latency for the single-cycle CPU.
    always_comb begin
        readValue = 16'h0000;
        unique case (offset)
            OFF_LED_LO: readValue = oLed[15:0];
            OFF_LED_HI: readValue = {8'h00, oLed[23:16]};
            OFF_SW_LO:  readValue = swSync[15:0];
            OFF_SW_HI:  readValue = {8'h00, swSync[23:16]};
            OFF_KEY:    readValue = {14'h0000, keyLevel, keyLatch};
            OFF_TIMER:  readValue = timerValue;
            default:    readValue = 16'h0000;
        endcase
    end

    assign oDataFromIo = rdEn ? readValue : 16'h0000;

    // LED output registers, written per half-word.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            oLed <= 24'h000000;
        end else begin
            if (wrEn && selLedLo) begin
                oLed[15:0] <= iDataToStore[15:0];
            end
            if (wrEn && selLedHi) begin
                oLed[23:16] <= iDataToStore[7:0];
            end
        end
    end

    // Sticky flag for strobes that hit an unmapped IO offset.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            oAddrError <= 1'b0;
        end else if ((rdEn || wrEn) && !mapped) begin
            oAddrError <= 1'b1;
        end
    end

    // Two-flop synchroniser for the asynchronous switch pads.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            swMeta <= 24'h000000;
            swSync <= 24'h000000;
        end else begin
            swMeta <= iSwitch;
            swSync <= swMeta;
        end
    end

    // Two-flop synchroniser for the raw key.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            keyMeta <= 1'b0;
            keySync <= 1'b0;
        end else begin
            keyMeta <= iKey;
            keySync <= keyMeta;
        end
    end

    // The level flips only after the synced key disagrees for a full window.
    assign keyFlip = (keySync != keyLevel) && (dbCnt == DB_LAST);
    assign keyRise = keyFlip && keySync;

    // Any return to the accepted level restarts the window.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            dbCnt    <= '0;
            keyLevel <= 1'b0;
        end else if (keySync == keyLevel) begin
            dbCnt <= '0;
        end else if (keyFlip) begin
            dbCnt    <= '0;
            keyLevel <= keySync;
        end else begin
            dbCnt <= dbCnt + 1'b1;
        end
    end

    // Latch is cleared by a status read or by writing 1 to bit0.
    assign keyClr = selKey && (rdEn || (wrEn && iDataToStore[0]));

    // Press latch: a new press outranks a same-cycle clear.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            keyLatch <= 1'b0;
        end else if (keyRise) begin
            keyLatch <= 1'b1;
        end else if (keyClr) begin
            keyLatch <= 1'b0;
        end
    end

`ifdef IO_BUS_TIMER_EN
    localparam int PRESCALE = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] preCnt;
    logic             msTick;
    logic             timerClr;
    logic [15:0]      msCount;

    assign msTick   = (preCnt == PRE_LAST);
    assign timerClr = wrEn && selTimer;

    // Millisecond prescaler; a timer write restarts the current ms.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            preCnt <= '0;
        end else if (timerClr || msTick) begin
            preCnt <= '0;
        end else begin
            preCnt <= preCnt + 1'b1;
        end
    end

    // Free-running 16-bit ms count; a write outranks the tick.
    always_ff @(posedge iClk or negedge iResetN) begin
        if (!iResetN) begin
            msCount <= 16'h0000;
        end else if (timerClr) begin
            msCount <= 16'h0000;
        end else if (msTick) begin
            msCount <= msCount + 16'd1;
        end
    end

    assign timerValue = msCount;
`else
    assign timerValue = 16'h0000;
`endif

endmodule
